// File: rtl/defs_pkg.sv
// rtl/defs_pkg.sv - shared AXI definitions and read-arbiter types
package defs_pkg;

    localparam int unsigned AxiIdWidth = 4;

    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;

    localparam logic MstIfu = 1'b0;
    localparam logic MstLsu = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        DATA = 2'b10
    } arb_state_t;

endpackage

// File: rtl/axi_rd_arbiter_rr.sv
// rtl/axi_rd_arbiter_rr.sv - two-input combinational round-robin pick
module rr_arbiter2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic       gnt_idx_o,
    output logic       gnt_valid_o
);

    always_comb begin
        gnt_valid_o = |req_i;
        if (req_i == 2'b11) begin
            gnt_idx_o = ptr_i;
        end else begin
            gnt_idx_o = req_i[1];
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - shares one AXI4 read port between IFU and LSU masters
module axi_rd_arbiter
    import defs_pkg::*;
#(
    parameter int unsigned NumMasters = 2,
    parameter int unsigned AxiIdWidth = defs_pkg::AxiIdWidth
) (
    input  logic                                  clk,
    input  logic                                  rst_n,

    input  logic [NumMasters-1:0]                 m_arvalid,
    output logic [NumMasters-1:0]                 m_arready,
    input  logic [NumMasters-1:0][AxiIdWidth-1:0] m_arid,
    input  logic [NumMasters-1:0][31:0]           m_araddr,
    input  logic [NumMasters-1:0][7:0]            m_arlen,
    input  logic [NumMasters-1:0][2:0]            m_arsize,
    input  logic [NumMasters-1:0][1:0]            m_arburst,

    output logic [NumMasters-1:0]                 m_rvalid,
    input  logic [NumMasters-1:0]                 m_rready,
    output logic [63:0]                           m_rdata,
    output logic [AxiIdWidth-1:0]                 m_rid,
    output logic [1:0]                            m_rresp,
    output logic                                  m_rlast,

    output logic                                  s_arvalid,
    input  logic                                  s_arready,
    output logic [AxiIdWidth-1:0]                 s_arid,
    output logic [31:0]                           s_araddr,
    output logic [7:0]                            s_arlen,
    output logic [2:0]                            s_arsize,
    output logic [1:0]                            s_arburst,

    input  logic                                  s_rvalid,
    output logic                                  s_rready,
    input  logic [AxiIdWidth-1:0]                 s_rid,
    input  logic [63:0]                           s_rdata,
    input  logic [1:0]                            s_rresp,
    input  logic                                  s_rlast,

    output logic                                  busy,
    output logic                                  grant,
    output logic                                  len_err
);

    arb_state_t state_q, state_d;
    logic       grant_q, grant_d;
    logic       rr_ptr_q, rr_ptr_d;
    logic [7:0] beat_cnt_q, beat_cnt_d;
    logic       len_err_q, len_err_d;

    logic       pick_idx;
    logic       pick_valid;
    logic       r_hs;

    rr_arbiter2 u_rr (
        .req_i       (m_arvalid[1:0]),
        .ptr_i       (rr_ptr_q),
        .gnt_idx_o   (pick_idx),
        .gnt_valid_o (pick_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= MstIfu;
            rr_ptr_q   <= MstIfu;
            beat_cnt_q <= 8'd0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            len_err_q  <= len_err_d;
        end
    end

    // Payload follows the registered owner; only the qualifiers are state-gated.
    assign s_arid    = m_arid[grant_q];
    assign s_araddr  = m_araddr[grant_q];
    assign s_arlen   = m_arlen[grant_q];
    assign s_arsize  = m_arsize[grant_q];
    assign s_arburst = m_arburst[grant_q];

    assign m_rdata = s_rdata;
    assign m_rid   = s_rid;
    assign m_rresp = s_rresp;
    assign m_rlast = s_rlast;

    assign r_hs = s_rvalid && s_rready;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        len_err_d  = len_err_q;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;
        m_arready  = '0;
        m_rvalid   = '0;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d    = pick_idx;
                    beat_cnt_d = m_arlen[pick_idx];
                    state_d    = ADDR;
                end
            end
            ADDR: begin
                s_arvalid          = 1'b1;
                m_arready[grant_q] = s_arready;
                if (s_arready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                s_rready          = m_rready[grant_q];
                m_rvalid[grant_q] = s_rvalid;
                if (r_hs) begin
                    // Saturate so an overlong burst keeps flagging rather than wrapping.
                    if (beat_cnt_q != 8'd0) begin
                        beat_cnt_d = beat_cnt_q - 8'd1;
                    end
                    if (s_rlast) begin
                        state_d  = IDLE;
                        rr_ptr_d = ~grant_q;
                        if (beat_cnt_q != 8'd0) begin
                            len_err_d = 1'b1;
                        end
                    end else if (beat_cnt_q == 8'd0) begin
                        len_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy    = (state_q != IDLE);
    assign grant   = grant_q;
    assign len_err = len_err_q;

endmodule
